uart_hex_reporter: RTL and testbench
====================================

UART_HEX_REPORTER -- requirements
Module: uart_hex_reporter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- FIFO_DEPTH_LOG2, 2, word FIFO depth = 2**FIFO_DEPTH_LOG2 (4 entries).
- SEND_PREFIX, 1, when 1 each word is preceded by "0x".

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- i_Clock, in, 1, sole clock, rising edge.
- i_Reset, in, 1, asynchronous, active-high reset.
- i_Word, in, 32, word to report.
- i_Word_Valid, in, 1, push request.
- o_Word_Ready, out, 1, FIFO not full.
- o_Tx_DV, out, 1, one-cycle byte-valid pulse to the UART transmitter.
- o_Tx_Byte, out, 8, ASCII byte for the transmitter; stable from the DV cycle until the matching done.
- i_Tx_Active, in, 1, transmitter busy.
- i_Tx_Done, in, 1, one-cycle end-of-byte pulse from the transmitter.
- o_Busy, out, 1, FIFO non-empty or FSM not IDLE.
- o_Overflow, out, 1, sticky flag: a push was dropped.

Function
REQ-003 A push SHALL occur when i_Word_Valid=1 and the FIFO is not full at the rising edge; the FIFO SHALL store i_Word.
REQ-004 A push with the FIFO full SHALL be dropped and SHALL set o_Overflow, even if a pop occurs in the same cycle; only reset SHALL clear o_Overflow.
REQ-005 o_Word_Ready SHALL equal the inverse of the registered full flag; the FIFO SHALL have no write-through bypass.
REQ-006 FIFO read/write pointers SHALL be FIFO_DEPTH_LOG2+1 bits wide and wrap modulo 2**(FIFO_DEPTH_LOG2+1).
- Full: pointer MSBs differ and the remaining bits are equal.
- Empty: pointers equal.
REQ-007 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged.
REQ-008 The FSM SHALL have the states IDLE, SEND, WAIT_DONE and GAP.
REQ-009 IDLE: if the FIFO is non-empty, the FSM SHALL pop the head word into a 32-bit shift register, set the character index to 0 and go to SEND.
REQ-010 SEND: if i_Tx_Active=0, the FSM SHALL drive o_Tx_DV=1 for exactly one cycle with o_Tx_Byte = the current character, then go to WAIT_DONE; otherwise it SHALL hold in SEND.
REQ-011 WAIT_DONE: on i_Tx_Done=1 the FSM SHALL go to GAP; a transmitter that never asserts done SHALL hold the FSM in WAIT_DONE indefinitely.
REQ-012 GAP: the FSM SHALL spend exactly one cycle here, then:
- last character sent: go to IDLE.
- otherwise: increment the index and go to SEND.
REQ-013 The character sequence per word SHALL be:
- if SEND_PREFIX=1: 0x30 ("0"), 0x78 ("x");
- then 8 hex digits, most significant nibble first;
- then 0x0D, 0x0A.
This gives 12 bytes per word (10 when SEND_PREFIX=0).
REQ-014 Nibble-to-ASCII conversion SHALL be:
- 0-9 map to 0x30-0x39.
- A-F map to uppercase 0x41-0x46.
REQ-015 Latency: for a push at edge k into an empty FIFO with the FSM in IDLE and the transmitter idle, o_Tx_DV SHALL be high in the cycle following edge k+2.
REQ-016 The FIFO SHALL continue to accept pushes while a word is being sent; words SHALL be emitted in push order with no interleaving.
REQ-017 o_Tx_DV SHALL never be asserted outside SEND and never twice for the same character.

Reset
REQ-018 While i_Reset=1, asynchronously and regardless of the clock, the block SHALL force:
- FSM to IDLE;
- pointers, index and shift register to 0;
- o_Tx_DV=0, o_Tx_Byte=0x00, o_Overflow=0, o_Busy=0, o_Word_Ready=1.
REQ-019 A reset during a word SHALL discard that word and all FIFO contents; the block SHALL NOT issue a resend after reset release.
REQ-020 The first push SHALL be accepted at the first rising edge after i_Reset deasserts.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Push 0xDEADBEEF, SEND_PREFIX=1, transmitter model with 20-cycle bytes -> bytes 30 78 44 45 41 44 42 45 45 46 0D 0A in order, then o_Busy=0.
- Push 0x0123ABCF with SEND_PREFIX=0 -> 30 31 32 33 41 42 43 46 0D 0A (10 DV pulses).
- Push 6 words back-to-back while the transmitter is stalled (i_Tx_Active=1) -> o_Word_Ready=0 after the 4th accepted word, o_Overflow=1, and exactly 4 words emitted, in order.
- Hold i_Tx_Active=1 for 50 cycles in SEND -> no DV; DV in the cycle after i_Tx_Active falls; exactly one DV per i_Tx_Done.
- Assert i_Reset after the 5th byte of a word with 2 words queued -> outputs reach reset values without a clock edge; no further DV until a new push.
- Continuous push/pop at FIFO occupancy 2 for 100 words with checker against a reference queue -> no loss and o_Overflow=0.

Source files
------------

// File: rtl/uart_hex_reporter.sv
// uart_hex_reporter: buffers 32-bit words in a small FIFO and streams each
// one to a byte-wide UART transmitter as ASCII hex followed by CR LF.
module uart_hex_reporter #(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter bit SEND_PREFIX     = 1'b1
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic [31:0] i_Word,
    input  logic        i_Word_Valid,
    output logic        o_Word_Ready,
    output logic        o_Tx_DV,
    output logic [7:0]  o_Tx_Byte,
    input  logic        i_Tx_Active,
    input  logic        i_Tx_Done,
    output logic        o_Busy,
    output logic        o_Overflow
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2 + 1;

    localparam logic [3:0] LAST_IDX  = SEND_PREFIX ? 4'd11 : 4'd9;
    localparam logic [3:0] HEX_FIRST = SEND_PREFIX ? 4'd2 : 4'd0;
    localparam logic [3:0] HEX_LAST  = HEX_FIRST + 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic [3:0]    idx_q, idx_d;
    logic [31:0]   sr_q, sr_d;
    logic          tx_dv_q, tx_dv_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic [31:0]   mem_q [DEPTH];

    logic          push;
    logic          pop;
    logic          empty;
    logic          is_hex;
    logic [3:0]    nib;
    logic [7:0]    cur_char;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = i_Word_Valid && !full_q;

    // FIFO pointer, full flag and sticky overflow update
    always_comb begin
        wr_ptr_d   = wr_ptr_q + (push ? PW'(1) : PW'(0));
        rd_ptr_d   = rd_ptr_q + (pop ? PW'(1) : PW'(0));
        full_d     = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                     (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]);
        overflow_d = overflow_q | (i_Word_Valid & full_q);
    end

    // Current ASCII character selected by the character index
    always_comb begin
        nib    = sr_q[31:28];
        is_hex = (idx_q >= HEX_FIRST) && (idx_q <= HEX_LAST);
        if (SEND_PREFIX && idx_q == 4'd0) begin
            cur_char = 8'h30;
        end else if (SEND_PREFIX && idx_q == 4'd1) begin
            cur_char = 8'h78;
        end else if (idx_q == LAST_IDX - 4'd1) begin
            cur_char = 8'h0D;
        end else if (idx_q == LAST_IDX) begin
            cur_char = 8'h0A;
        end else if (nib < 4'd10) begin
            cur_char = 8'h30 + {4'h0, nib};
        end else begin
            cur_char = 8'h37 + {4'h0, nib};
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!empty) state_d = SEND;
            SEND:      if (!i_Tx_Active) state_d = WAIT_DONE;
            WAIT_DONE: if (i_Tx_Done) state_d = GAP;
            GAP:       state_d = (idx_q == LAST_IDX) ? IDLE : SEND;
            default:   state_d = IDLE;
        endcase
    end

    // FSM outputs: pop, byte launch, index and shift register updates
    always_comb begin
        pop       = 1'b0;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        idx_d     = idx_q;
        sr_d      = sr_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    sr_d  = mem_q[rd_ptr_q[PW-2:0]];
                    idx_d = 4'd0;
                end
            end
            SEND: begin
                if (!i_Tx_Active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = cur_char;
                end
            end
            WAIT_DONE: begin
            end
            GAP: begin
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + 4'd1;
                    if (is_hex) sr_d = {sr_q[27:0], 4'h0};
                end
            end
            default: begin
            end
        endcase
    end

    // Control and datapath registers, cleared asynchronously
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            idx_q      <= 4'd0;
            sr_q       <= 32'd0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            idx_q      <= idx_d;
            sr_q       <= sr_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge i_Clock) begin
        if (push) mem_q[wr_ptr_q[PW-2:0]] <= i_Word;
    end

    assign o_Word_Ready = !full_q;
    assign o_Tx_DV      = tx_dv_q;
    assign o_Tx_Byte    = tx_byte_q;
    assign o_Overflow   = overflow_q;
    assign o_Busy       = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_uart_hex_reporter.sv
// tb_uart_hex_reporter: directed checks of the hex reporter against
// hand-computed byte streams and a simple transmitter model.
module tb_uart_hex_reporter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] word = 32'd0;
    logic        valid = 1'b0;
    logic        valid0 = 1'b0;
    logic        stall = 1'b0;
    int          tx_len = 20;

    logic        ready, dv, busy, ovf, act, done;
    logic [7:0]  txb;
    logic        ready0, dv0, busy0, ovf0, act0, done0;
    logic [7:0]  txb0;

    int          cnt = 0;
    int          cnt0 = 0;
    int          dv_total = 0;
    int          done_total = 0;
    int          bad_dv = 0;
    logic [7:0]  bytes [$];
    logic [7:0]  bytes0 [$];

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [7:0] EXP_DB [12] = '{8'h30, 8'h78, 8'h44, 8'h45, 8'h41, 8'h44,
                                8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    logic [7:0] EXP_P0 [10] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42,
                                8'h43, 8'h46, 8'h0D, 8'h0A};
    logic [31:0] W6 [6] = '{32'h11111111, 32'h2222AAAA, 32'h3333BBBB,
                            32'h4444CCCC, 32'h5555DDDD, 32'h6666EEEE};

    always #5 clk = ~clk;

    assign act  = stall || (cnt != 0);
    assign act0 = (cnt0 != 0);

    uart_hex_reporter #(.FIFO_DEPTH_LOG2(2), .SEND_PREFIX(1'b1)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Word(word), .i_Word_Valid(valid),
        .o_Word_Ready(ready), .o_Tx_DV(dv), .o_Tx_Byte(txb),
        .i_Tx_Active(act), .i_Tx_Done(done), .o_Busy(busy),
        .o_Overflow(ovf)
    );

    uart_hex_reporter #(.FIFO_DEPTH_LOG2(2), .SEND_PREFIX(1'b0)) dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_Word(word), .i_Word_Valid(valid0),
        .o_Word_Ready(ready0), .o_Tx_DV(dv0), .o_Tx_Byte(txb0),
        .i_Tx_Active(act0), .i_Tx_Done(done0), .o_Busy(busy0),
        .o_Overflow(ovf0)
    );

    // transmitter model for the prefixed instance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (dv) begin
                bytes.push_back(txb);
                dv_total <= dv_total + 1;
                if (cnt != 0) bad_dv <= bad_dv + 1;
                cnt <= tx_len;
            end else if (cnt == 1) begin
                cnt        <= 0;
                done       <= 1'b1;
                done_total <= done_total + 1;
            end else if (cnt > 1) begin
                cnt <= cnt - 1;
            end
        end
    end

    // transmitter model for the unprefixed instance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0  <= 0;
            done0 <= 1'b0;
        end else begin
            done0 <= 1'b0;
            if (dv0) begin
                bytes0.push_back(txb0);
                cnt0 <= 3;
            end else if (cnt0 == 1) begin
                cnt0  <= 0;
                done0 <= 1'b1;
            end else if (cnt0 > 1) begin
                cnt0 <= cnt0 - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        @(negedge clk);
        word  = w;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int c = 0;
        while (bytes.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk(tag, 32'(bytes.size() >= n), 32'd1);
    endtask

    function automatic logic [3:0] a2n(input logic [7:0] b);
        logic [7:0] v;
        v = (b >= 8'h41) ? b - 8'h37 : b - 8'h30;
        return v[3:0];
    endfunction

    task automatic check_word(input string tag, input int base,
                              input logic [31:0] exp);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < 8; i++) w = {w[27:0], a2n(bytes[base + 2 + i])};
        chk({tag, "_frame"}, {bytes[base], bytes[base + 1],
            bytes[base + 10], bytes[base + 11]}, 32'h30780D0A);
        chk({tag, "_word"}, w, exp);
    endtask

    initial begin
        logic        rdy_after [6];
        logic [31:0] refq [$];
        int          nsent;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_dv", {31'd0, dv}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_byte", {24'd0, txb}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // DEADBEEF with latency check
        @(negedge clk);
        word  = 32'hDEADBEEF;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #1;
        chk("lat_k1_dv", {31'd0, dv}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_k2_dv", {31'd0, dv}, 32'd1);
        chk("lat_k2_byte", {24'd0, txb}, 32'h30);
        wait_bytes("db_wait", 12, 600);
        for (int i = 0; i < 12; i++)
            chk($sformatf("db_byte%0d", i), {24'd0, bytes[i]}, {24'd0, EXP_DB[i]});
        repeat (30) @(posedge clk);
        #1;
        chk("db_busy", {31'd0, busy}, 32'd0);
        chk("db_count", 32'(bytes.size()), 32'd12);
        chk("db_dv_done", 32'(dv_total), 32'(done_total));

        // unprefixed instance
        @(negedge clk);
        word   = 32'h0123ABCF;
        valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        chk("p0_count", 32'(bytes0.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("p0_byte%0d", i), {24'd0, bytes0[i]}, {24'd0, EXP_P0[i]});
        chk("p0_busy", {31'd0, busy0}, 32'd0);

        // transmitter held active for 50 cycles in SEND
        bytes.delete();
        stall = 1'b1;
        push(32'hCAFE0042);
        repeat (50) @(posedge clk);
        #1;
        chk("stall_nodv", 32'(bytes.size()), 32'd0);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_release_dv", {31'd0, dv}, 32'd1);
        wait_bytes("stall_wait", 12, 600);
        check_word("stall", 0, 32'hCAFE0042);
        repeat (30) @(posedge clk);
        #1;
        chk("stall_dv_done", 32'(dv_total), 32'(done_total));
        chk("stall_bad_dv", 32'(bad_dv), 32'd0);

        // overflow with a stalled transmitter
        bytes.delete();
        stall = 1'b1;
        push(32'hA5A5A5A5);
        repeat (5) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            word  = W6[i];
            valid = 1'b1;
            @(posedge clk);
            #1;
            rdy_after[i] = ready;
        end
        @(negedge clk);
        valid = 1'b0;
        chk("ovf_ready_3rd", {31'd0, rdy_after[2]}, 32'd1);
        chk("ovf_ready_4th", {31'd0, rdy_after[3]}, 32'd0);
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        stall = 1'b0;
        wait_bytes("ovf_wait", 60, 2500);
        check_word("ovf_a", 0, 32'hA5A5A5A5);
        for (int i = 0; i < 4; i++)
            check_word($sformatf("ovf_w%0d", i), 12 * (i + 1), W6[i]);
        repeat (200) @(posedge clk);
        #1;
        chk("ovf_count", 32'(bytes.size()), 32'd60);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);

        // reset in the middle of a word with two words queued
        bytes.delete();
        push(32'h01010101);
        push(32'h02020202);
        push(32'h03030303);
        wait_bytes("rst_mid_wait", 5, 600);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("amid_dv", {31'd0, dv}, 32'd0);
        chk("amid_byte", {24'd0, txb}, 32'd0);
        chk("amid_busy", {31'd0, busy}, 32'd0);
        chk("amid_ready", {31'd0, ready}, 32'd1);
        chk("amid_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("amid_no_resend", 32'(bytes.size()), 32'd5);
        chk("amid_idle", {31'd0, busy}, 32'd0);

        // first edge after reset accepts a push; then streaming
        tx_len = 2;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bytes.delete();
        rst   = 1'b0;
        word  = 32'h5A000000;
        valid = 1'b1;
        @(posedge clk);
        #1;
        chk("first_edge_push", {31'd0, busy}, 32'd1);
        @(negedge clk);
        valid = 1'b0;
        refq.push_back(32'h5A000000);
        for (int i = 1; i < 3; i++) begin
            push(32'h9E3779B9 * i ^ i);
            refq.push_back(32'h9E3779B9 * i ^ i);
        end
        nsent = 3;
        for (int k = 0; k < 100; k++) begin
            wait_bytes($sformatf("strm_wait%0d", k), 12 * (k + 1), 400);
            check_word($sformatf("strm%0d", k), 12 * k, refq.pop_front());
            if (nsent < 100) begin
                push(32'h9E3779B9 * nsent ^ nsent);
                refq.push_back(32'h9E3779B9 * nsent ^ nsent);
                nsent++;
            end
        end
        repeat (50) @(posedge clk);
        #1;
        chk("strm_ovf", {31'd0, ovf}, 32'd0);
        chk("strm_busy", {31'd0, busy}, 32'd0);
        chk("strm_count", 32'(bytes.size()), 32'd1200);
        chk("strm_bad_dv", 32'(bad_dv), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
